// File: rtl/stepper_pulse_scheduler_if.sv
// rtl/stepper_pulse_scheduler_if.sv - command/pulse bundle between SCARA controller and the pulse scheduler
interface stepper_pulse_scheduler_if #(
  parameter int STEP_W = 8
);
  logic [STEP_W-1:0] steps1;
  logic [STEP_W-1:0] steps2;
  logic              dir1;
  logic              dir2;
  logic              dataReady;
  logic              step1_out;
  logic              step2_out;
  logic              dir1_out;
  logic              dir2_out;
  logic              busy;
  logic              stepperReady;

  // controller side
  modport master (
    output steps1, steps2, dir1, dir2, dataReady,
    input  step1_out, step2_out, dir1_out, dir2_out, busy, stepperReady
  );

  // scheduler side
  modport slave (
    input  steps1, steps2, dir1, dir2, dataReady,
    output step1_out, step2_out, dir1_out, dir2_out, busy, stepperReady
  );
endinterface

// File: rtl/stepper_pulse_scheduler.sv
// rtl/stepper_pulse_scheduler.sv - two-axis STEP/DIR pulse scheduler; SCARA_STEP_INTERP_EN selects Bresenham interpolation
module stepper_pulse_scheduler #(
  parameter int STEP_W      = 8,
  parameter int STEP_PERIOD = 5000,
  parameter int PULSE_HIGH  = 100,
  parameter int DIR_SETUP   = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  stepper_pulse_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, DONE} state_t;

  localparam int LOW_CYC = STEP_PERIOD - PULSE_HIGH;
  localparam int TMAX    = (DIR_SETUP > STEP_PERIOD) ? DIR_SETUP : STEP_PERIOD;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int EW      = STEP_W + 2;

  state_t            state, state_n;
  logic [TW-1:0]     tmr;
  logic              tmr_done;
  logic [STEP_W-1:0] s1_q, s2_q;
  logic              dir1_q, dir2_q;
  logic [STEP_W-1:0] major;
  logic [STEP_W-1:0] ticks;
  logic              enter_high;
  logic              fire1, fire2;

  assign major      = (s1_q >= s2_q) ? s1_q : s2_q;
  assign enter_high = (state_n == HIGH) && (state != HIGH);

  // end-of-phase detect for the timed states
  always_comb begin
    tmr_done = 1'b0;
    case (state)
      SETUP:   tmr_done = (tmr == TW'(DIR_SETUP - 1));
      HIGH:    tmr_done = (tmr == TW'(PULSE_HIGH - 1));
      LOW:     tmr_done = (tmr == TW'(LOW_CYC - 1));
      default: tmr_done = 1'b0;
    endcase
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.dataReady) state_n = LOAD;
      LOAD:    state_n = (major == '0) ? DONE : SETUP;
      SETUP:   if (tmr_done) state_n = HIGH;
      HIGH:    if (tmr_done) state_n = LOW;
      LOW:     if (tmr_done) state_n = (ticks == STEP_W'(1)) ? DONE : HIGH;
      DONE:    state_n = IDLE;
      default: state_n = DONE;
    endcase
  end

`ifdef SCARA_STEP_INTERP_EN
  logic                 axis1_major;
  logic [STEP_W-1:0]    minor;
  logic signed [EW-1:0] err, err_sub, err_n;
  logic                 minor_fire;

  // Bresenham tick decision; ties make axis 1 major and both axes fire every tick
  always_comb begin
    axis1_major = (s1_q >= s2_q);
    minor       = axis1_major ? s2_q : s1_q;
    err_sub     = err - $signed({2'b00, minor});
    minor_fire  = (err_sub < 0);
    err_n       = minor_fire ? (err_sub + $signed({2'b00, major})) : err_sub;
    fire1       = axis1_major | minor_fire;
    fire2       = ~axis1_major | minor_fire;
  end

  // error accumulator: seeded in LOAD, advanced once per tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= '0;
    end else if (state == LOAD) begin
      err <= $signed({2'b00, major >> 1});
    end else if (enter_high) begin
      err <= err_n;
    end
  end
`else
  logic [STEP_W-1:0] rem1, rem2;

  // each axis fires while it still has steps left; the shorter one finishes early
  always_comb begin
    fire1 = (rem1 != '0);
    fire2 = (rem2 != '0);
  end

  // per-axis remaining step counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem1 <= '0;
      rem2 <= '0;
    end else if (state == LOAD) begin
      rem1 <= s1_q;
      rem2 <= s2_q;
    end else if (enter_high) begin
      if (fire1) rem1 <= rem1 - 1'b1;
      if (fire2) rem2 <= rem2 - 1'b1;
    end
  end
`endif

  // state, timers, command capture and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= DONE;
      tmr              <= '0;
      s1_q             <= '0;
      s2_q             <= '0;
      dir1_q           <= 1'b0;
      dir2_q           <= 1'b0;
      ticks            <= '0;
      bus.step1_out    <= 1'b0;
      bus.step2_out    <= 1'b0;
      bus.dir1_out     <= 1'b0;
      bus.dir2_out     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.stepperReady <= 1'b0;
    end else begin
      state <= state_n;
      // timer restarts on every state change and rests outside the timed states
      if (state_n != state || state_n == IDLE || state_n == DONE) tmr <= '0;
      else                                                        tmr <= tmr + 1'b1;

      if (state == IDLE && bus.dataReady) begin
        s1_q   <= bus.steps1;
        s2_q   <= bus.steps2;
        dir1_q <= bus.dir1;
        dir2_q <= bus.dir2;
      end

      if (state == LOAD) begin
        bus.dir1_out <= dir1_q;
        bus.dir2_out <= dir2_q;
        ticks        <= major;
      end

      if (state == LOW && tmr_done) ticks <= ticks - 1'b1;

      if (enter_high) begin
        bus.step1_out <= fire1;
        bus.step2_out <= fire2;
      end else if (state_n != HIGH) begin
        bus.step1_out <= 1'b0;
        bus.step2_out <= 1'b0;
      end

      bus.busy         <= (state_n == LOAD) || (state_n == SETUP) ||
                          (state_n == HIGH) || (state_n == LOW);
      bus.stepperReady <= (state == DONE);
    end
  end

endmodule
